mips_mc_control_fsm: RTL



---
 rtl/mips_mc_control_fsm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mips_mc_control_fsm.sv
// mips_mc_control_fsm: multicycle MIPS main controller (Moore FSM, retired-instruction counter).
// Define MIPS_MC_MEM_HANDSHAKE_EN to stall memory states on mem_ready with a TIMEOUT bus error.
module mips_mc_control_fsm #(
    parameter int OPCODE_W    = 6,
    parameter int TIMEOUT     = 15,
    parameter bit SUPPORT_BNE = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                pc_write,
    output logic                branch,
    output logic                branch_ne,
    output logic [1:0]          alu_op,
    output logic                illegal,
    output logic                timeout_err,
    output logic                instr_done,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
        MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, ADDIEX = 4'd9,
        ADDIWB = 4'd10, JUMP = 4'd11, ERROR = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic             bne_q, bne_d, illegal_q, illegal_d, rdy, tmo;
    logic [CNT_W-1:0] count_q;
    logic             op_lw, op_sw, op_r, op_beq, op_bne, op_addi, op_j;

    assign op_lw   = opcode == OPCODE_W'(6'h23);
    assign op_sw   = opcode == OPCODE_W'(6'h2b);
    assign op_r    = opcode == OPCODE_W'(6'h00);
    assign op_beq  = opcode == OPCODE_W'(6'h04);
    assign op_bne  = SUPPORT_BNE && opcode == OPCODE_W'(6'h05);
    assign op_addi = opcode == OPCODE_W'(6'h08);
    assign op_j    = opcode == OPCODE_W'(6'h02);

`ifdef MIPS_MC_MEM_HANDSHAKE_EN
    // wait_q counts stalled cycles in the current memory state; any state change clears it
    logic [7:0] wait_q, wait_d;
    logic       mem_st, tmo_err_q;
    assign mem_st      = state_q == FETCH || state_q == MEMRD || state_q == MEMWR;
    assign rdy         = mem_ready;
    assign tmo         = mem_st && !mem_ready && wait_q == 8'(TIMEOUT - 1);
    assign wait_d      = state_d != state_q ? 8'd0 : mem_st ? wait_q + 8'd1 : wait_q;
    assign timeout_err = tmo_err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            tmo_err_q <= tmo_err_q | tmo;
        end
    end
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign rdy              = 1'b1;
    assign tmo              = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            bne_q     <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bne_q     <= bne_d;
            illegal_q <= illegal_d;
            count_q   <= count_q + CNT_W'(instr_done);
        end
    end

    always_comb begin
        state_d    = state_q;
        bne_d      = bne_q;
        illegal_d  = illegal_q;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        alu_op     = 2'b00;
        instr_done = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = rdy;
                pc_write  = rdy;
                alu_src_b = 2'b01;
                state_d   = tmo ? ERROR : rdy ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                bne_d     = op_bne;
                illegal_d = illegal_q | !(op_lw | op_sw | op_r | op_beq | op_bne | op_addi | op_j);
                state_d   = (op_lw | op_sw) ? MEMADR : op_r ? EXEC : (op_beq | op_bne) ? BRANCH :
                            op_addi ? ADDIEX : op_j ? JUMP : ERROR;
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = op_lw ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                state_d  = tmo ? ERROR : rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = rdy;
                instr_done = rdy;
                state_d    = tmo ? ERROR : rdy ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b01;
                pc_src     = 2'b01;
                branch     = !bne_q;
                branch_ne  = bne_q;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = FETCH;
            end
            ERROR: alu_op = 2'b11;
            default: begin
                alu_op    = 2'b11;
                illegal_d = 1'b1;
                state_d   = ERROR;
            end
        endcase
    end

    assign illegal     = illegal_q;
    assign instr_count = count_q;
    assign state       = state_q;
endmodule
